// File: rtl/cp0_exc_ctrl.sv
// rtl/cp0_exc_ctrl.sv - M-stage exception/interrupt sequencer for CP0 (option: CP0_EXC_TIMER_INT_EN)
module cp0_exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallM,
    input  logic        validM,
    input  logic [31:0] pcM,
    input  logic        in_delayslotM,
    input  logic [31:0] addrM,
    input  logic        adel_fetchM,
    input  logic        riM,
    input  logic        ovM,
    input  logic        syscallM,
    input  logic        breakM,
    input  logic        adel_loadM,
    input  logic        adesM,
    input  logic        eretM,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic        timer_int_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] bad_addr_o,
    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_DRAIN} state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t      state;
    logic [7:0]  code_q;
    logic [31:0] pc_q;
    logic        ds_q;
    logic [31:0] bad_q;
    logic [31:0] target_q;
    logic [3:0]  cnt_q;

    logic        int_pending;
    logic [7:0]  det_code;
    logic [31:0] det_bad;
    logic        detect;
    logic        fire;
    logic        unused_bits;

`ifdef CP0_EXC_TIMER_INT_EN
    // Timer is treated as IP7 before Cause has caught up with it
    assign int_pending = status_i[0] & ~status_i[1] &
                         ((|(cause_i[15:8] & status_i[15:8])) | (timer_int_i & status_i[15]));
    assign unused_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};
`else
    assign int_pending = status_i[0] & ~status_i[1] & (|(cause_i[15:8] & status_i[15:8]));
    assign unused_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0], timer_int_i};
`endif

    // Fixed-priority cause selection; only load/store/fetch faults carry an address
    always_comb begin
        det_code = 8'h00;
        det_bad  = 32'h0;
        if (int_pending) begin
            det_code = 8'h01;
        end else if (adel_fetchM) begin
            det_code = 8'h04;
            det_bad  = pcM;
        end else if (riM) begin
            det_code = 8'h0a;
        end else if (ovM) begin
            det_code = 8'h0c;
        end else if (syscallM) begin
            det_code = 8'h08;
        end else if (breakM) begin
            det_code = 8'h09;
        end else if (adel_loadM) begin
            det_code = 8'h04;
            det_bad  = addrM;
        end else if (adesM) begin
            det_code = 8'h05;
            det_bad  = addrM;
        end else if (eretM) begin
            det_code = 8'h0e;
        end
    end

    assign detect = (state == S_IDLE) && validM && !stallM && (det_code != 8'h00);
    assign fire   = (state == S_COMMIT) && !stallM;

    // Sequencer: capture in IDLE, commit once when unstalled, then drain the flush window
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            code_q   <= 8'h00;
            pc_q     <= 32'h0;
            ds_q     <= 1'b0;
            bad_q    <= 32'h0;
            target_q <= 32'h0;
            cnt_q    <= 4'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (detect) begin
                        code_q   <= det_code;
                        pc_q     <= pcM;
                        ds_q     <= in_delayslotM;
                        bad_q    <= det_bad;
                        target_q <= (det_code == 8'h0e) ? epc_i : EXC_VECTOR;
                        state    <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    if (!stallM) begin
                        cnt_q <= DRAIN_LOAD;
                        state <= (FLUSH_CYCLES == 1) ? S_IDLE : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Commit fields are visible only in the single unstalled COMMIT cycle
    assign excepttype_o        = fire ? {24'h0, code_q} : 32'h0;
    assign current_inst_addr_o = fire ? pc_q : 32'h0;
    assign is_in_delayslot_o   = fire & ds_q;
    assign bad_addr_o          = fire ? bad_q : 32'h0;
    assign redirect_valid_o    = fire;
    assign redirect_pc_o       = fire ? target_q : 32'h0;
    assign flush_o             = fire | (state == S_DRAIN);
    assign busy_o              = (state != S_IDLE);

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb/tb_cp0_exc_ctrl.sv - directed and randomized checks of cp0_exc_ctrl
module tb_cp0_exc_ctrl;

    localparam logic [31:0] VEC = 32'hBFC00380;
    localparam int          FC  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallM, validM, in_delayslotM;
    logic [31:0] pcM, addrM;
    logic        adel_fetchM, riM, ovM, syscallM, breakM, adel_loadM, adesM, eretM;
    logic [31:0] status_i, cause_i, epc_i;
    logic        timer_int_i;
    logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, redirect_pc_o;
    logic        is_in_delayslot_o, flush_o, redirect_valid_o, busy_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cp0_exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .stallM(stallM), .validM(validM), .pcM(pcM),
        .in_delayslotM(in_delayslotM), .addrM(addrM),
        .adel_fetchM(adel_fetchM), .riM(riM), .ovM(ovM), .syscallM(syscallM),
        .breakM(breakM), .adel_loadM(adel_loadM), .adesM(adesM), .eretM(eretM),
        .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i), .timer_int_i(timer_int_i),
        .excepttype_o(excepttype_o), .current_inst_addr_o(current_inst_addr_o),
        .is_in_delayslot_o(is_in_delayslot_o), .bad_addr_o(bad_addr_o),
        .flush_o(flush_o), .redirect_valid_o(redirect_valid_o),
        .redirect_pc_o(redirect_pc_o), .busy_o(busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] et, input logic [31:0] pc,
                             input logic ds, input logic [31:0] bad, input logic fl,
                             input logic rv, input logic [31:0] rpc, input logic bz);
        chk({tag, ".excepttype"}, excepttype_o, et);
        chk({tag, ".inst_addr"}, current_inst_addr_o, pc);
        chk({tag, ".delayslot"}, {31'h0, is_in_delayslot_o}, {31'h0, ds});
        chk({tag, ".bad_addr"}, bad_addr_o, bad);
        chk({tag, ".flush"}, {31'h0, flush_o}, {31'h0, fl});
        chk({tag, ".redirect_valid"}, {31'h0, redirect_valid_o}, {31'h0, rv});
        chk({tag, ".redirect_pc"}, redirect_pc_o, rpc);
        chk({tag, ".busy"}, {31'h0, busy_o}, {31'h0, bz});
    endtask

    task automatic check_quiet(input string tag, input logic bz);
        check_out(tag, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, bz);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        stallM = 0; validM = 0; in_delayslotM = 0;
        adel_fetchM = 0; riM = 0; ovM = 0; syscallM = 0; breakM = 0;
        adel_loadM = 0; adesM = 0; eretM = 0;
    endtask

    // Reference: the cause table in priority order, first raised entry wins
    task automatic ref_model(output logic [31:0] code, output logic [31:0] bad,
                             output logic [31:0] target);
        logic [7:0] codes [9];
        logic       req   [9];
        logic       ip;
        codes = '{8'h01, 8'h04, 8'h0a, 8'h0c, 8'h08, 8'h09, 8'h04, 8'h05, 8'h0e};
        ip = (status_i[0] == 1'b1) && (status_i[1] == 1'b0) &&
             ((((cause_i >> 8) & (status_i >> 8)) & 32'hff) != 0);
`ifdef CP0_EXC_TIMER_INT_EN
        if (status_i[0] && !status_i[1] && timer_int_i && status_i[15]) ip = 1'b1;
`endif
        req = '{ip, adel_fetchM, riM, ovM, syscallM, breakM, adel_loadM, adesM, eretM};
        code = 0; bad = 0; target = VEC;
        for (int i = 0; i < 9; i++) begin
            if (req[i] && code == 0) begin
                code = {24'h0, codes[i]};
                if (i == 1) bad = pcM;
                if (i == 6 || i == 7) bad = addrM;
                if (i == 8) target = epc_i;
            end
        end
    endtask

    // Event inputs are already applied in an IDLE cycle; walk detect, stalls, commit, drain, idle
    task automatic run_event(input string tag, input logic [31:0] code, input logic [31:0] pc,
                             input logic ds, input logic [31:0] bad, input logic [31:0] rpc,
                             input int stalls, input logic junk);
        #1;
        check_quiet({tag, "/detect"}, 1'b0);
        tick();
        clear_in();
        for (int s = 0; s < stalls; s++) begin
            stallM = 1;
            #1;
            check_quiet({tag, "/stall"}, 1'b1);
            tick();
        end
        stallM = 0;
        #1;
        check_out({tag, "/commit"}, code, pc, ds, bad, 1'b1, 1'b1, rpc, 1'b1);
        tick();
        for (int d = 1; d < FC; d++) begin
            if (junk) begin
                validM = 1; adesM = 1; ovM = 1; addrM = $urandom; stallM = 1'($urandom_range(0, 1));
            end
            #1;
            check_out({tag, "/drain"}, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
            tick();
            clear_in();
        end
        #1;
        check_quiet({tag, "/idle"}, 1'b0);
    endtask

    logic [31:0] m_code, m_bad, m_tgt;

    initial begin
        clear_in();
        rst = 0; pcM = 0; addrM = 0; status_i = 0; cause_i = 0; epc_i = 0; timer_int_i = 0;
        tick(); tick();
        check_quiet("reset", 1'b0);
        rst = 1;
        tick();
        check_quiet("post_reset", 1'b0);

        // Overflow, no stall
        validM = 1; ovM = 1; pcM = 32'hBFC00100;
        run_event("ov", 32'h0c, 32'hBFC00100, 1'b0, 32'h0, VEC, 0, 1'b0);

        // RI beats ADES; delay-slot flag carried through
        tick();
        validM = 1; riM = 1; adesM = 1; addrM = 32'h80000003; pcM = 32'hBFC00200; in_delayslotM = 1;
        run_event("prio", 32'h0a, 32'hBFC00200, 1'b1, 32'h0, VEC, 0, 1'b0);

        // ADES alone reports the data address
        tick();
        validM = 1; adesM = 1; addrM = 32'h80000003; pcM = 32'hBFC00204;
        run_event("ades", 32'h05, 32'hBFC00204, 1'b0, 32'h80000003, VEC, 0, 1'b0);

        // Interrupt enabled, then masked by EXL
        tick();
        validM = 1; status_i = 32'h00000401; cause_i = 32'h00000400; pcM = 32'hBFC00300;
        run_event("int", 32'h01, 32'hBFC00300, 1'b0, 32'h0, VEC, 0, 1'b0);
        tick();
        validM = 1; status_i = 32'h00000403;
        #1;
        check_quiet("int_exl/detect", 1'b0);
        tick();
        clear_in();
        #1;
        check_quiet("int_exl/none", 1'b0);
        status_i = 0; cause_i = 0;

        // Syscall held in COMMIT by three stall cycles
        tick();
        validM = 1; syscallM = 1; pcM = 32'hBFC00400;
        run_event("stall", 32'h08, 32'hBFC00400, 1'b0, 32'h0, VEC, 3, 1'b0);

        // ERET redirects to EPC; ADES during drain is ignored
        tick();
        validM = 1; eretM = 1; epc_i = 32'hBFC00420; pcM = 32'hBFC00500;
        run_event("eret", 32'h0e, 32'hBFC00500, 1'b0, 32'h0, 32'hBFC00420, 0, 1'b1);

        // Reset mid-drain, then an overflow accepted straight away
        tick();
        validM = 1; ovM = 1; pcM = 32'hBFC00600;
        tick();
        clear_in();
        #1;
        check_out("rst_mid/commit", 32'h0c, 32'hBFC00600, 1'b0, 32'h0, 1'b1, 1'b1, VEC, 1'b1);
        tick();
        rst = 0;
        #1;
        chk("rst_mid/flush_before", {31'h0, flush_o}, 32'h1);
        tick();
        rst = 1;
        #1;
        check_quiet("rst_mid/after", 1'b0);
        validM = 1; ovM = 1; pcM = 32'hBFC00700;
        run_event("rst_mid/ov", 32'h0c, 32'hBFC00700, 1'b0, 32'h0, VEC, 0, 1'b0);

        // Randomized events against the cause-table model
        for (int t = 0; t < 60; t++) begin
            tick();
            validM = ($urandom_range(0, 4) != 0);
            stallM = ($urandom_range(0, 4) == 0);
            in_delayslotM = 1'($urandom_range(0, 1));
            pcM = $urandom; addrM = $urandom; epc_i = $urandom;
            adel_fetchM = ($urandom_range(0, 7) == 0);
            riM         = ($urandom_range(0, 7) == 0);
            ovM         = ($urandom_range(0, 7) == 0);
            syscallM    = ($urandom_range(0, 7) == 0);
            breakM      = ($urandom_range(0, 7) == 0);
            adel_loadM  = ($urandom_range(0, 7) == 0);
            adesM       = ($urandom_range(0, 7) == 0);
            eretM       = ($urandom_range(0, 7) == 0);
            status_i    = $urandom;
            cause_i     = ($urandom_range(0, 1) == 1) ? $urandom : 32'h0;
            timer_int_i = 1'($urandom_range(0, 1));
            ref_model(m_code, m_bad, m_tgt);
            if (validM && !stallM && m_code != 0) begin
                run_event("rand", m_code, pcM, in_delayslotM, m_bad, m_tgt,
                          $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            end else begin
                #1;
                check_quiet("rand_none/detect", 1'b0);
                tick();
                clear_in();
                #1;
                check_quiet("rand_none/next", 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the bench always ends
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
